// File: rtl/sram_resp.sv
// sram_resp: on-chip stand-in for a 16-bit asynchronous SRAM. It answers the
// bridge's ce_n/oe_n/we_n/ub_n/lb_n pins from an internal word array.
// Latency: reads drive RD_LAT cycles after the request is sampled; writes land
// on the sampling edge.
// Backpressure: none. busy high during the post-reset clear sweep means
// requests are ignored. The bus drops off combinationally when the read
// request goes away.
// Ports:
//   clk, rst           clock, async active-high reset
//   sram_data          bidirectional data; driven only while answering a read
//   sram_addr, *_n     SRAM pin inputs (word address, strobes, lane enables)
//   busy               clear sweep in progress
//   oor_err            sticky: an access used address bits above ADDR_W-1
//   rd_cnt, wr_cnt     saturating counts of accepted reads / writes
module sram_resp #(
  parameter int ADDR_W     = 12,
  parameter int RD_LAT     = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] sram_data,
  input  logic [19:0] sram_addr,
  input  logic        sram_ce_n,
  input  logic        sram_oe_n,
  input  logic        sram_we_n,
  input  logic        sram_ub_n,
  input  logic        sram_lb_n,
  output logic        busy,
  output logic        oor_err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  typedef enum logic [1:0] {S_CLR, S_IDLE, S_RD_WAIT, S_RD_DRV} state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam state_t     RST_STATE = (CLR_ON_RST != 0) ? S_CLR : S_IDLE;
  localparam logic       RST_BUSY  = (CLR_ON_RST != 0);
  localparam logic [3:0] LAT_INIT  = 4'(RD_LAT - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_busy;
  logic                r_oor;
  logic [15:0]         r_rd_cnt;
  logic [15:0]         r_wr_cnt;
  logic [19:0]         r_rd_addr;
  logic                r_rd_inr;
  logic [3:0]          r_lat;
  logic [15:0]         r_dat;
  logic                r_wr_hold;
  logic [19:0]         r_wr_hold_addr;
  logic [15:0]         r_mem [DEPTH];

  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_idx;
  logic              w_active;
  logic              w_do_wr;
  logic              w_wr_new;
  logic              w_rd_new;
  logic [15:0]       w_rd_now;
  logic [15:0]       w_rd_cap;
  logic              w_drv;

  // we_n low wins over oe_n: a write request can never also be a read request.
  assign w_wr_req   = ~sram_ce_n & ~sram_we_n;
  assign w_rd_req   = ~sram_ce_n & sram_we_n & ~sram_oe_n;
  assign w_in_range = (sram_addr[19:ADDR_W] == '0);
  assign w_idx      = sram_addr[ADDR_W-1:0];
  assign w_active   = (r_state != S_CLR);

  // Outside the sweep every write is performed: in IDLE directly, in RD_WAIT
  // it aborts the read, and in RD_DRV it implies the read request is gone.
  assign w_do_wr  = w_active & w_wr_req;
  // A write held on the same address rewrites the word but counts only once.
  assign w_wr_new = w_do_wr & ~(r_wr_hold & (sram_addr == r_wr_hold_addr));

  // A new read is a read request in IDLE, or one whose address moved while a
  // read was already in progress. A held read on the same address is not new.
  assign w_rd_new = w_rd_req &
                    ((r_state == S_IDLE) |
                     (((r_state == S_RD_WAIT) | (r_state == S_RD_DRV)) &
                      (sram_addr != r_rd_addr)));

  assign w_rd_now = w_in_range ? r_mem[w_idx] : 16'h0000;
  assign w_rd_cap = r_rd_inr ? r_mem[r_rd_addr[ADDR_W-1:0]] : 16'h0000;

  // Drive is purely combinational so strobe changes release the bus at once.
  assign w_drv = (r_state == S_RD_DRV) & w_rd_req;
  assign sram_data[7:0]  = (w_drv & ~sram_lb_n) ? r_dat[7:0]  : 8'hzz;
  assign sram_data[15:8] = (w_drv & ~sram_ub_n) ? r_dat[15:8] : 8'hzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RST_STATE;
      r_ptr          <= '0;
      r_busy         <= RST_BUSY;
      r_oor          <= 1'b0;
      r_rd_cnt       <= '0;
      r_wr_cnt       <= '0;
      r_rd_addr      <= '0;
      r_rd_inr       <= 1'b0;
      r_lat          <= '0;
      r_dat          <= '0;
      r_wr_hold      <= 1'b0;
      r_wr_hold_addr <= '0;
    end else begin
      r_wr_hold      <= w_do_wr;
      r_wr_hold_addr <= sram_addr;

      if (w_wr_new && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_rd_new && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      if ((w_do_wr || w_rd_new) && !w_in_range) r_oor <= 1'b1;

      case (r_state)
        S_CLR: begin
          r_ptr <= r_ptr + 1'b1;
          if (&r_ptr) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          if (w_wr_req) begin
            r_state <= S_IDLE;
          end else if (w_rd_new) begin
            r_rd_addr <= sram_addr;
            r_rd_inr  <= w_in_range;
            if (RD_LAT == 1) begin
              r_state <= S_RD_DRV;
              r_dat   <= w_rd_now;
            end else begin
              r_state <= S_RD_WAIT;
              r_lat   <= LAT_INIT;
            end
          end else if (!w_rd_req) begin
            r_state <= S_IDLE;
          end else if (r_state == S_RD_WAIT) begin
            if (r_lat == 4'd1) begin
              r_dat   <= w_rd_cap;
              r_state <= S_RD_DRV;
            end else begin
              r_lat <= r_lat - 4'd1;
            end
          end
        end
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_CLR) begin
      r_mem[r_ptr] <= 16'h0000;
    end else if (w_do_wr && w_in_range) begin
      if (!sram_lb_n) r_mem[w_idx][7:0]  <= sram_data[7:0];
      if (!sram_ub_n) r_mem[w_idx][15:8] <= sram_data[15:8];
    end
  end

  assign busy    = r_busy;
  assign oor_err = r_oor;
  assign rd_cnt  = r_rd_cnt;
  assign wr_cnt  = r_wr_cnt;

endmodule

// File: tb/tb_sram_resp.sv
// tb_sram_resp: drives sram_resp (ADDR_W=4, RD_LAT=2, clear sweep on) through
// its pin protocol and checks it against a word-array model of the SRAM.
// The data bus has pull-ups, so a released lane reads back as 8'hFF.
module tb_sram_resp;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  tri1  [15:0] sram_data;
  logic        tb_en = 1'b0;
  logic [15:0] tb_dat = 16'h0000;
  logic [19:0] sram_addr = '0;
  logic        sram_ce_n = 1'b1;
  logic        sram_oe_n = 1'b1;
  logic        sram_we_n = 1'b1;
  logic        sram_ub_n = 1'b0;
  logic        sram_lb_n = 1'b0;
  logic        busy;
  logic        oor_err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  always #5 clk = ~clk;

  assign sram_data = tb_en ? tb_dat : 16'hzzzz;

  sram_resp #(.ADDR_W(AW), .RD_LAT(LAT), .CLR_ON_RST(1)) dut (
    .clk(clk), .rst(rst), .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy),
    .oor_err(oor_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model
  logic [15:0] m_mem [DEPTH];
  int          m_rd;
  int          m_wr;
  logic        m_oor;

  function automatic logic m_inr(input logic [19:0] a);
    return (a >> AW) == 20'd0;
  endfunction

  function automatic logic [15:0] m_rdval(input logic [19:0] a);
    return m_inr(a) ? m_mem[a % DEPTH] : 16'h0000;
  endfunction

  // What the pulled-up bus shows when data d is returned on the enabled lanes.
  function automatic logic [15:0] m_bus(input logic [15:0] d, input logic ub, input logic lb);
    return {ub ? 8'hFF : d[15:8], lb ? 8'hFF : d[7:0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
    m_rd = 0; m_wr = 0; m_oor = 1'b0;
  endtask

  task automatic pins_idle();
    sram_ce_n = 1'b1; sram_oe_n = 1'b1; sram_we_n = 1'b1;
    sram_ub_n = 1'b0; sram_lb_n = 1'b0; tb_en = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                          input logic ub, input logic lb);
    sram_addr = a; tb_dat = d; tb_en = 1'b1;
    sram_ce_n = 1'b0; sram_we_n = 1'b0; sram_oe_n = 1'b1;
    sram_ub_n = ub; sram_lb_n = lb;
    @(posedge clk); #1;
    pins_idle();
    @(posedge clk); #1;
    m_wr++;
    if (m_inr(a)) begin
      if (!lb) m_mem[a % DEPTH][7:0]  = d[7:0];
      if (!ub) m_mem[a % DEPTH][15:8] = d[15:8];
    end else m_oor = 1'b1;
  endtask

  // Returns the bus during the first latency cycle and on the drive cycle.
  task automatic do_read(input logic [19:0] a, input logic ub, input logic lb,
                         output logic [15:0] wait_bus, output logic [15:0] dat);
    sram_addr = a; sram_ce_n = 1'b0; sram_we_n = 1'b1; sram_oe_n = 1'b0;
    sram_ub_n = ub; sram_lb_n = lb;
    @(posedge clk); #1;
    wait_bus = sram_data;
    repeat (LAT - 1) begin @(posedge clk); #1; end
    dat = sram_data;
    pins_idle();
    @(posedge clk); #1;
    m_rd++;
    if (!m_inr(a)) m_oor = 1'b1;
  endtask

  task automatic test_reset();
    int cyc;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp += 5;
    if (busy !== 1'b1)       begin n_bad++; $display("FAIL reset_busy got %b want 1", busy); end
    if (rd_cnt !== 16'd0)    begin n_bad++; $display("FAIL reset_rd_cnt got %h want 0", rd_cnt); end
    if (wr_cnt !== 16'd0)    begin n_bad++; $display("FAIL reset_wr_cnt got %h want 0", wr_cnt); end
    if (oor_err !== 1'b0)    begin n_bad++; $display("FAIL reset_oor got %b want 0", oor_err); end
    if (sram_data !== 16'hFFFF) begin n_bad++; $display("FAIL reset_bus got %h want released", sram_data); end
    // A write held through the whole sweep must be ignored.
    sram_addr = 20'd2; tb_dat = 16'h1234; tb_en = 1'b1;
    sram_ce_n = 1'b0; sram_we_n = 1'b0;
    rst = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (!busy) break;
    end
    pins_idle();
    m_reset();
    n_cmp += 2;
    if (cyc != 16)        begin n_bad++; $display("FAIL sweep_len got %0d want 16", cyc); end
    if (wr_cnt !== 16'd0) begin n_bad++; $display("FAIL sweep_wr_ignored got %h want 0", wr_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_readback();
    logic [15:0] wb, d;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(20'(i), 1'b0, 1'b0, wb, d);
      n_cmp += 2;
      if (wb !== 16'hFFFF) begin n_bad++; $display("FAIL clr_wait_z[%0d] got %h want released", i, wb); end
      if (d !== 16'h0000)  begin n_bad++; $display("FAIL clr_data[%0d] got %h want 0000", i, d); end
    end
    n_cmp++;
    if (rd_cnt !== 16'(m_rd)) begin n_bad++; $display("FAIL clr_rd_cnt got %0d want %0d", rd_cnt, m_rd); end
  endtask

  task automatic test_basic_rw();
    logic [15:0] wb, d;
    do_write(20'd3, 16'hA55A, 1'b0, 1'b0);
    do_read(20'd3, 1'b0, 1'b0, wb, d);
    n_cmp += 4;
    if (wb !== 16'hFFFF) begin n_bad++; $display("FAIL rw_wait_z got %h want released", wb); end
    if (d !== 16'hA55A)  begin n_bad++; $display("FAIL rw_data got %h want a55a", d); end
    if (wr_cnt !== 16'(m_wr)) begin n_bad++; $display("FAIL rw_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    if (rd_cnt !== 16'(m_rd)) begin n_bad++; $display("FAIL rw_rd_cnt got %0d want %0d", rd_cnt, m_rd); end
  endtask

  task automatic test_lanes();
    logic [15:0] wb, d;
    do_write(20'd5, 16'h1234, 1'b0, 1'b0);
    do_write(20'd5, 16'hFF00, 1'b0, 1'b1);
    do_read(20'd5, 1'b0, 1'b0, wb, d);
    n_cmp++;
    if (d !== 16'hFF34) begin n_bad++; $display("FAIL lane_merge got %h want ff34", d); end
    do_write(20'd5, 16'h5A00, 1'b0, 1'b1);
    do_read(20'd5, 1'b1, 1'b0, wb, d);
    n_cmp++;
    if (d !== 16'hFF34) begin n_bad++; $display("FAIL lane_lo_only got %h want ff34", d); end
    do_read(20'd5, 1'b0, 1'b1, wb, d);
    n_cmp++;
    if (d !== 16'h5AFF) begin n_bad++; $display("FAIL lane_hi_only got %h want 5aff", d); end
  endtask

  task automatic test_oe_release();
    logic [15:0] wb, d;
    sram_addr = 20'd3; sram_ce_n = 1'b0; sram_we_n = 1'b1; sram_oe_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_rd++;
    n_cmp++;
    if (sram_data !== m_mem[3]) begin n_bad++; $display("FAIL oe_drive got %h want %h", sram_data, m_mem[3]); end
    #2 sram_oe_n = 1'b1;
    #1;
    n_cmp++;
    if (sram_data !== 16'hFFFF) begin n_bad++; $display("FAIL oe_release got %h want released", sram_data); end
    sram_addr = 20'd7; tb_dat = 16'h7E57; tb_en = 1'b1; sram_we_n = 1'b0;
    @(posedge clk); #1;
    pins_idle();
    @(posedge clk); #1;
    m_wr++;
    m_mem[7] = 16'h7E57;
    do_read(20'd7, 1'b0, 1'b0, wb, d);
    n_cmp += 2;
    if (d !== 16'h7E57) begin n_bad++; $display("FAIL oe_write_after got %h want 7e57", d); end
    if (wr_cnt !== 16'(m_wr)) begin n_bad++; $display("FAIL oe_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
  endtask

  task automatic test_oor();
    logic [15:0] wb, d;
    n_cmp++;
    if (oor_err !== 1'b0) begin n_bad++; $display("FAIL oor_pre got %b want 0", oor_err); end
    do_write(20'h00013, 16'hBEEF, 1'b0, 1'b0);
    n_cmp++;
    if (oor_err !== 1'b1) begin n_bad++; $display("FAIL oor_set got %b want 1", oor_err); end
    do_read(20'd3, 1'b0, 1'b0, wb, d);
    n_cmp++;
    if (d !== 16'hA55A) begin n_bad++; $display("FAIL oor_word3 got %h want a55a", d); end
    do_read(20'h00013, 1'b0, 1'b0, wb, d);
    n_cmp++;
    if (d !== 16'h0000) begin n_bad++; $display("FAIL oor_read got %h want 0000", d); end
  endtask

  task automatic test_addr_change();
    sram_addr = 20'd1; sram_ce_n = 1'b0; sram_we_n = 1'b1; sram_oe_n = 1'b0;
    @(posedge clk); #1;
    sram_addr = 20'd2;
    @(posedge clk); #1;
    n_cmp++;
    if (sram_data !== 16'hFFFF) begin n_bad++; $display("FAIL restart_wait got %h want released", sram_data); end
    @(posedge clk); #1;
    n_cmp++;
    if (sram_data !== m_mem[2]) begin n_bad++; $display("FAIL restart_data got %h want %h", sram_data, m_mem[2]); end
    repeat (2) begin @(posedge clk); #1; end
    pins_idle();
    @(posedge clk); #1;
    m_rd += 2;
    n_cmp++;
    if (rd_cnt !== 16'(m_rd)) begin n_bad++; $display("FAIL restart_rd_cnt got %0d want %0d", rd_cnt, m_rd); end
  endtask

  task automatic test_held_write();
    logic [15:0] wb, d;
    sram_addr = 20'd9; tb_dat = 16'h0909; tb_en = 1'b1;
    sram_ce_n = 1'b0; sram_we_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    sram_addr = 20'd10; tb_dat = 16'h1010;
    repeat (2) begin @(posedge clk); #1; end
    pins_idle();
    @(posedge clk); #1;
    m_wr += 2; m_mem[9] = 16'h0909; m_mem[10] = 16'h1010;
    n_cmp++;
    if (wr_cnt !== 16'(m_wr)) begin n_bad++; $display("FAIL held_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    do_read(20'd9, 1'b0, 1'b0, wb, d);
    n_cmp++;
    if (d !== 16'h0909) begin n_bad++; $display("FAIL held_w9 got %h want 0909", d); end
    do_read(20'd10, 1'b0, 1'b0, wb, d);
    n_cmp++;
    if (d !== 16'h1010) begin n_bad++; $display("FAIL held_w10 got %h want 1010", d); end
  endtask

  task automatic test_random();
    logic [19:0] a;
    logic [15:0] wb, d, exp;
    logic        ub, lb;
    for (int i = 0; i < 80; i++) begin
      a = 20'($urandom);
      if ($urandom_range(0, 7) != 0) a = a % DEPTH;
      ub = ($urandom_range(0, 3) == 0);
      lb = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, 16'($urandom), ub, lb);
      end else begin
        exp = m_bus(m_rdval(a), ub, lb);
        do_read(a, ub, lb, wb, d);
        n_cmp += 2;
        if (wb !== 16'hFFFF) begin n_bad++; $display("FAIL rand_wait[%0d] got %h want released", i, wb); end
        if (d !== exp) begin n_bad++; $display("FAIL rand_read[%0d] addr %h got %h want %h", i, a, d, exp); end
      end
    end
    n_cmp += 3;
    if (rd_cnt !== 16'(m_rd)) begin n_bad++; $display("FAIL rand_rd_cnt got %0d want %0d", rd_cnt, m_rd); end
    if (wr_cnt !== 16'(m_wr)) begin n_bad++; $display("FAIL rand_wr_cnt got %0d want %0d", wr_cnt, m_wr); end
    if (oor_err !== m_oor)    begin n_bad++; $display("FAIL rand_oor got %b want %b", oor_err, m_oor); end
  endtask

  task automatic test_rst_midread();
    int cyc;
    sram_addr = 20'd3; sram_ce_n = 1'b0; sram_we_n = 1'b1; sram_oe_n = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp += 5;
    if (sram_data !== 16'hFFFF) begin n_bad++; $display("FAIL mrst_bus got %h want released", sram_data); end
    if (busy !== 1'b1)    begin n_bad++; $display("FAIL mrst_busy got %b want 1", busy); end
    if (rd_cnt !== 16'd0) begin n_bad++; $display("FAIL mrst_rd_cnt got %h want 0", rd_cnt); end
    if (wr_cnt !== 16'd0) begin n_bad++; $display("FAIL mrst_wr_cnt got %h want 0", wr_cnt); end
    if (oor_err !== 1'b0) begin n_bad++; $display("FAIL mrst_oor got %b want 0", oor_err); end
    pins_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    cyc = 0;
    while (busy && cyc < 40) begin @(posedge clk); #1; cyc++; end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_sweep_done got %b want 0 after %0d cycles", busy, cyc); end
  endtask

  initial begin
    m_reset();
    pins_idle();
    test_reset();
    test_clear_readback();
    test_basic_rw();
    test_lanes();
    test_oe_release();
    test_oor();
    test_addr_change();
    test_held_write();
    test_random();
    test_rst_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
